cic_rate_ctrl: RTL and testbench
================================

# cic_rate_ctrl

Rate-change sequencer and output qualifier for the receive-chain variable-decimation 5-stage CIC. It accepts decimation requests from the host control path and rejects unsupported values. Each accepted rate is applied to the CIC only on an output-sample boundary, which keeps the CIC sample counter from overrunning a smaller limit. The block then discards the CIC's transient output samples until the comb chain has settled at the new rate, and sits between the CIC output and the downstream receive FIFO.

## Interface
- STAGES, 5, CIC stage count; the number of settled outputs discarded after each rate change or reset.
- DEFAULT_DEC, 40, decimation driven after reset; must be a supported value.
- OUT_WIDTH, 18, width of the CIC output sample.

Ports (clock and reset first):
- clock  in  1  system clock; everything is on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  one-cycle pulse: host requests the decimation on req_decimation.
- req_decimation  in  6  requested decimation.
- req_ack  out  1  one-cycle pulse, 1 cycle after req_valid, for every request.
- req_err  out  1  valid with req_ack; 1 = unsupported value, request dropped.
- busy  out  1  high in WAIT_BOUNDARY or FLUSH.
- cic_decimation  out  6  decimation driven to the CIC.
- cic_out_strobe  in  1  CIC output strobe.
- cic_out_data  in  OUT_WIDTH  CIC output sample; valid the cycle after cic_out_strobe.
- out_valid  out  1  qualified sample strobe to downstream.
- out_data  out  OUT_WIDTH  qualified sample (signed).

## Operation
- Supported decimations: 2, 3, 4, 5, 6, 8, 10, 12, 16, 20, 24, 40. Any other value (including 0, 1, 7) gives req_ack with req_err=1 and no state or register change.
- The FSM has three states: IDLE, WAIT_BOUNDARY and FLUSH. It also keeps a pending register (6 bits) and a flush counter (0..STAGES).
- IDLE:
  - A valid request equal to cic_decimation is acked as a no-op and the state is unchanged.
  - A valid request that differs is written to pending, and the FSM goes to WAIT_BOUNDARY.
- WAIT_BOUNDARY, on cic_out_strobe=1:
  - cic_decimation <= pending; flush counter <= 0; go to FLUSH.
  - This is the boundary because the CIC sample counter is 0 in that cycle.
- FLUSH:
  - Each cic_out_strobe increments the flush counter and the matching sample is discarded.
  - When the counter reaches STAGES, the FSM goes to IDLE. The strobe that makes the count STAGES is itself discarded.
- A valid supported request arriving in WAIT_BOUNDARY or FLUSH:
  - overwrites pending, and the FSM goes to (or stays in) WAIT_BOUNDARY;
  - last request wins, and any flush in progress is abandoned.
  - If req_valid coincides with a boundary strobe in WAIT_BOUNDARY, the old pending value is applied on that edge and the new request takes effect next cycle (FLUSH -> WAIT_BOUNDARY).
  - A request equal to cic_decimation while busy is still treated as a change, which forces a flush.
- Output qualification, IDLE only:
  - cic_out_strobe at cycle t causes out_data <= cic_out_data at t+1 and out_valid=1 at t+2 (one cycle only).
  - A strobe is qualified by the state in the cycle it arrives.
- If strobes stop, WAIT_BOUNDARY holds indefinitely; there is no timeout. busy stays high.

## Timing
- Reset (rst_n=0 at an edge):
  - state=FLUSH, flush counter=0, cic_decimation=DEFAULT_DEC, pending=DEFAULT_DEC;
  - out_valid=0, out_data=0, req_ack=0, req_err=0, busy=1.
  - Post-reset, the first STAGES CIC outputs are discarded.
- Reset mid-operation discards the pending request and gives no ack for a request in flight.
- req_valid to req_ack: 1 cycle. req_valid pulses must be at least 2 cycles apart. Back-to-back pulses are not required to be acked individually.
- Change latency, from first boundary strobe to first qualified out_valid: STAGES+1 output periods plus 2 cycles.
- out_valid never asserts in two consecutive cycles.
- cic_decimation changes only on an edge where cic_out_strobe=1 and state=WAIT_BOUNDARY.

## Test plan
- Reset with in-strobe every 4 clocks and CIC at 40 -> first 5 CIC strobes give no out_valid, 6th does; cic_decimation=40 throughout; busy falls after 5th strobe.
- IDLE at 40, request 8 -> req_ack, req_err=0, busy=1; cic_decimation stays 40 until next cic_out_strobe, then 8 on that edge; next 5 strobes suppressed, then out_valid with out_data equal to cic_out_data sampled 1 cycle after strobe.
- Request 7, then 0 -> req_ack with req_err=1 each; cic_decimation, busy, output stream unchanged.
- Request 10, then request 20 during FLUSH after 2 discarded samples -> returns to WAIT_BOUNDARY; cic_decimation becomes 20 at next boundary; 5 more discards before output resumes.
- IDLE at 40, request 40 -> ack, busy never asserts, no sample dropped; request 3 with strobes halted -> busy held and cic_decimation=40 indefinitely until strobes resume.
- Assert rst_n=0 during WAIT_BOUNDARY with pending 5 -> cic_decimation=40, pending lost, no out_valid until 5 post-reset strobes discarded.

Source files
------------

// File: rtl/cic_rate_ctrl_if.sv
// rtl/cic_rate_ctrl_if.sv - host request, CIC rate and qualified sample signals for cic_rate_ctrl
interface cic_rate_ctrl_if #(
    parameter int OUT_WIDTH = 18
);
    logic                 req_valid;
    logic [5:0]           req_decimation;
    logic                 req_ack;
    logic                 req_err;
    logic                 busy;
    logic [5:0]           cic_decimation;
    logic                 cic_out_strobe;
    logic [OUT_WIDTH-1:0] cic_out_data;
    logic                 out_valid;
    logic [OUT_WIDTH-1:0] out_data;

    modport slave (
        input  req_valid, req_decimation, cic_out_strobe, cic_out_data,
        output req_ack, req_err, busy, cic_decimation, out_valid, out_data
    );

    modport master (
        output req_valid, req_decimation, cic_out_strobe, cic_out_data,
        input  req_ack, req_err, busy, cic_decimation, out_valid, out_data
    );
endinterface

// File: rtl/cic_rate_ctrl.sv
// rtl/cic_rate_ctrl.sv - CIC decimation change sequencer with boundary apply and settle flush
module cic_rate_ctrl #(
    parameter int         STAGES      = 5,
    parameter logic [5:0] DEFAULT_DEC = 6'd40,
    parameter int         OUT_WIDTH   = 18
) (
    input logic            clock,
    input logic            rst_n,
    cic_rate_ctrl_if.slave bus
);
    localparam int CW = $clog2(STAGES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [5:0]           pending_q, pending_d;
    logic [5:0]           cic_dec_q, cic_dec_d;
    logic [CW-1:0]        flush_cnt_q, flush_cnt_d;
    logic                 requeue_q, requeue_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 qual_q, qual_d;
    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                 busy;
    logic                 dec_ok;
    logic                 req_ok;

    function automatic logic is_supported(input logic [5:0] d);
        case (d)
            6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd8,
            6'd10, 6'd12, 6'd16, 6'd20, 6'd24, 6'd40: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    assign dec_ok = is_supported(bus.req_decimation);
    assign req_ok = bus.req_valid && dec_ok;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q     <= ST_FLUSH;
            pending_q   <= DEFAULT_DEC;
            cic_dec_q   <= DEFAULT_DEC;
            flush_cnt_q <= '0;
            requeue_q   <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            qual_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cic_dec_q   <= cic_dec_d;
            flush_cnt_q <= flush_cnt_d;
            requeue_q   <= requeue_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            qual_q      <= qual_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        cic_dec_d   = cic_dec_q;
        flush_cnt_d = flush_cnt_q;
        requeue_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_ok && (bus.req_decimation != cic_dec_q)) begin
                    pending_d = bus.req_decimation;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The strobe cycle is where the CIC sample counter sits at 0
                if (bus.cic_out_strobe) begin
                    cic_dec_d   = pending_q;
                    flush_cnt_d = '0;
                    state_d     = ST_FLUSH;
                    if (req_ok) begin
                        pending_d = bus.req_decimation;
                        requeue_d = 1'b1;
                    end
                end else if (req_ok) begin
                    pending_d = bus.req_decimation;
                end
            end
            ST_FLUSH: begin
                if (req_ok) begin
                    pending_d = bus.req_decimation;
                    state_d   = ST_WAIT;
                end else if (requeue_q) begin
                    state_d = ST_WAIT;
                end else if (bus.cic_out_strobe) begin
                    flush_cnt_d = flush_cnt_q + CW'(1);
                    if (flush_cnt_q == CW'(STAGES - 1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_FLUSH;
        endcase
    end

    always_comb begin
        busy        = (state_q != ST_IDLE);
        ack_d       = bus.req_valid;
        err_d       = bus.req_valid && !dec_ok;
        qual_d      = bus.cic_out_strobe && (state_q == ST_IDLE);
        out_valid_d = qual_q;
        out_data_d  = qual_q ? bus.cic_out_data : out_data_q;
    end

    assign bus.req_ack        = ack_q;
    assign bus.req_err        = err_q;
    assign bus.busy           = busy;
    assign bus.cic_decimation = cic_dec_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_data       = out_data_q;
endmodule

// File: tb/tb_cic_rate_ctrl.sv
// tb/tb_cic_rate_ctrl.sv - directed and randomized bench for cic_rate_ctrl against a drop-count model
module tb_cic_rate_ctrl;
    localparam int         STAGES = 5;
    localparam int         OW     = 18;
    localparam logic [5:0] DEF    = 6'd40;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cic_rate_ctrl_if #(.OUT_WIDTH(OW)) bus_if ();

    cic_rate_ctrl #(
        .STAGES      (STAGES),
        .DEFAULT_DEC (DEF),
        .OUT_WIDTH   (OW)
    ) dut (
        .clock (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int sup_tbl[12] = '{2, 3, 4, 5, 6, 8, 10, 12, 16, 20, 24, 40};

    // Model: a pending rate is applied at the next strobe; then STAGES strobes are dropped
    int          m_dec;
    int          m_pend;
    bit          m_pend_v;
    int          m_drop;
    bit          m_q1;
    logic [OW-1:0] m_data;
    bit          e_ack, e_err, e_ov;

    bit strb_on;
    bit strb_rand;
    int strb_per;
    int strb_cnt;
    int cyc = 0;
    int last_req = -10;

    function automatic bit supported(input int d);
        foreach (sup_tbl[i]) if (sup_tbl[i] == d) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dec    = DEF;
        m_pend   = DEF;
        m_pend_v = 1'b0;
        m_drop   = STAGES;
        m_q1     = 1'b0;
        m_data   = '0;
        e_ack    = 1'b0;
        e_err    = 1'b0;
        e_ov     = 1'b0;
    endtask

    task automatic cycle(input bit req, input int val, input bit rst);
        bit            strobe;
        bit            busy_before;
        logic [OW-1:0] d;
        strobe = 1'b0;
        if (strb_on) begin
            if (strb_cnt == 0) begin
                strobe   = 1'b1;
                strb_cnt = strb_rand ? int'($urandom_range(1, 5)) : strb_per - 1;
            end else begin
                strb_cnt--;
            end
        end
        d = OW'($urandom);
        rst_n                 = !rst;
        bus_if.req_valid      = req;
        bus_if.req_decimation = 6'(val);
        bus_if.cic_out_strobe = strobe;
        bus_if.cic_out_data   = d;
        if (req) last_req = cyc;
        if (rst) begin
            model_reset();
        end else begin
            busy_before = m_pend_v || (m_drop > 0);
            e_ov = m_q1;
            if (m_q1) m_data = d;
            m_q1 = strobe && !busy_before;
            if (strobe) begin
                if (m_pend_v) begin
                    m_dec    = m_pend;
                    m_pend_v = 1'b0;
                    m_drop   = STAGES;
                end else if (m_drop > 0) begin
                    m_drop--;
                end
            end
            e_ack = req;
            e_err = req && !supported(val);
            if (req && supported(val) && (busy_before || val != m_dec)) begin
                m_pend   = val;
                m_pend_v = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("req_ack", 32'(bus_if.req_ack), 32'(e_ack));
        chk("req_err", 32'(bus_if.req_err), 32'(e_err));
        chk("busy", 32'(bus_if.busy), 32'(m_pend_v || (m_drop > 0)));
        chk("cic_decimation", 32'(bus_if.cic_decimation), 32'(m_dec));
        chk("out_valid", 32'(bus_if.out_valid), 32'(e_ov));
        chk("out_data", 32'(bus_if.out_data), 32'(m_data));
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0);
    endtask

    initial begin
        bus_if.req_valid      = 1'b0;
        bus_if.req_decimation = '0;
        bus_if.cic_out_strobe = 1'b0;
        bus_if.cic_out_data   = '0;
        rst_n     = 1'b0;
        strb_on   = 1'b0;
        strb_rand = 1'b0;
        strb_per  = 4;
        strb_cnt  = 0;
        model_reset();
        @(negedge clk);

        cycle(1'b0, 0, 1'b1);
        cycle(1'b1, 8, 1'b1);

        // Post-reset flush with a strobe every 4 clocks
        strb_on = 1'b1;
        run(40);

        cycle(1'b1, 8, 1'b0);
        run(60);

        cycle(1'b1, 7, 1'b0);
        run(6);
        cycle(1'b1, 0, 1'b0);
        run(20);

        // Second request lands mid-flush
        cycle(1'b1, 10, 1'b0);
        run(14);
        cycle(1'b1, 20, 1'b0);
        run(60);

        cycle(1'b1, 20, 1'b0);
        run(20);
        cycle(1'b1, 40, 1'b0);
        run(60);
        cycle(1'b1, 40, 1'b0);
        run(20);

        // Strobes halted: WAIT_BOUNDARY must hold
        strb_on = 1'b0;
        cycle(1'b1, 3, 1'b0);
        run(40);
        strb_on  = 1'b1;
        strb_cnt = 0;
        run(60);

        // Reset while waiting for a boundary with pending 5
        strb_on = 1'b0;
        cycle(1'b1, 5, 1'b0);
        run(3);
        cycle(1'b0, 0, 1'b1);
        strb_on  = 1'b1;
        strb_cnt = 0;
        run(40);

        strb_rand = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                cycle(1'b0, 0, 1'b1);
            end else if ((cyc - last_req) >= 2 && $urandom_range(0, 14) == 0) begin
                if ($urandom_range(0, 9) < 7)
                    cycle(1'b1, sup_tbl[$urandom_range(0, 11)], 1'b0);
                else
                    cycle(1'b1, int'($urandom_range(0, 63)), 1'b0);
            end else begin
                cycle(1'b0, 0, 1'b0);
            end
        end
        run(80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
